alu_wide_seq: RTL and testbench

//  Multi-cycle sequencer that runs NBYTES-wide ADD/SUB/SHL/SHR on the 8-bit combinational ALU, one byte per cycle.

---
 rtl/alu_wide_seq_pkg.sv | 24 ++
 rtl/alu_wide_seq.sv | 154 +++++++++++++++
 tb/tb_alu_wide_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_seq_pkg.sv
// Shared types and ALU opcodes for the wide-op byte sequencer.
// Opcode values match the 8-bit ALU decode.
package alu_wide_seq_pkg;

  typedef enum logic [1:0] {
    K_ADD = 2'd0,
    K_SUB = 2'd1,
    K_SHL = 2'd2,
    K_SHR = 2'd3
  } wkind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wseq_st_t;

  localparam logic [2:0] opADD      = 3'd0;
  localparam logic [2:0] opSUB      = 3'd1;
  localparam logic [2:0] opOTYPE    = 3'd6;
  localparam logic [2:0] fnSHIFTL_O = 3'd1;
  localparam logic [2:0] fnSHIFTR_O = 3'd2;

endpackage

// File: rtl/alu_wide_seq.sv
// Wide ADD/SUB/SHL/SHR sequencer driving a shared 8-bit ALU,
// one byte per cycle, with carry chained between passes.
module alu_wide_seq
  import alu_wide_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  wkind_t                REQ_KIND,
  input  logic [8*NBYTES-1:0]   REQ_A,
  input  logic [8*NBYTES-1:0]   REQ_B,
  input  logic                  REQ_CIN,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [8*NBYTES-1:0]   RSP_RESULT,
  output logic                  RSP_COUT,
  input  logic                  ABORT,
  output logic [7:0]            ALU_A,
  output logic [7:0]            ALU_B,
  output logic [2:0]            ALU_OP,
  output logic [2:0]            ALU_FUNC,
  output logic                  ALU_OVF_IN,
  output logic                  ALU_FLAG_IN,
  input  logic [7:0]            ALU_OUT,
  input  logic                  ALU_OVF_OUT
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  wseq_st_t r_state;
  wseq_st_t w_next;

  wkind_t        r_kind;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_cout;

  logic [7:0] w_a_byte;
  logic [7:0] w_b_byte;
  logic       w_last;
  logic       w_sub_bo;
  logic       w_carry_nx;

  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

  assign w_last = (r_kind == K_SHR) ? (r_idx == '0)
                                    : (r_idx == LAST);

  // Borrow is derived locally so the ALU's SUB overflow semantics
  // never leak into the chained result.
  assign w_sub_bo = (w_a_byte < w_b_byte) |
                    ((w_a_byte == w_b_byte) & r_carry);

  assign w_carry_nx = (r_kind == K_SUB) ? w_sub_bo : ALU_OVF_OUT;

  assign REQ_READY   = (r_state == IDLE);
  assign RSP_VALID   = (r_state == DONE);
  assign RSP_RESULT  = r_result;
  assign RSP_COUT    = r_cout;
  assign ALU_FLAG_IN = 1'b0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (REQ_VALID) w_next = RUN;
      RUN: begin
        if (ABORT)       w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE: if (ABORT || RSP_READY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ALU_A      = 8'h00;
    ALU_B      = 8'h00;
    ALU_OP     = opADD;
    ALU_FUNC   = 3'd0;
    ALU_OVF_IN = 1'b0;
    if (r_state == RUN) begin
      ALU_A      = w_a_byte;
      ALU_OVF_IN = r_carry;
      unique case (r_kind)
        K_ADD: begin
          ALU_B  = w_b_byte;
          ALU_OP = opADD;
        end
        K_SUB: begin
          ALU_B  = w_b_byte;
          ALU_OP = opSUB;
        end
        K_SHL: begin
          ALU_OP   = opOTYPE;
          ALU_FUNC = fnSHIFTL_O;
        end
        K_SHR: begin
          ALU_OP   = opOTYPE;
          ALU_FUNC = fnSHIFTR_O;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_kind   <= K_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (REQ_VALID) begin
            r_a     <= REQ_A;
            r_b     <= REQ_B;
            r_kind  <= REQ_KIND;
            r_carry <= REQ_CIN;
            r_idx   <= (REQ_KIND == K_SHR) ? LAST : '0;
          end
        end
        RUN: begin
          if (!ABORT) begin
            r_result[{r_idx, 3'b000} +: 8] <= ALU_OUT;
            r_carry <= w_carry_nx;
            if (w_last)               r_cout <= w_carry_nx;
            else if (r_kind == K_SHR) r_idx  <= r_idx - 1'b1;
            else                      r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq (NBYTES=2) with a behavioural
// 8-bit ALU hooked to the sequencer's ALU port.
module tb_alu_wide_seq;
  import alu_wide_seq_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  wkind_t      REQ_KIND;
  logic [15:0] REQ_A;
  logic [15:0] REQ_B;
  logic        REQ_CIN;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_RESULT;
  logic        RSP_COUT;
  logic        ABORT;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [2:0]  ALU_OP;
  logic [2:0]  ALU_FUNC;
  logic        ALU_OVF_IN;
  logic        ALU_FLAG_IN;
  logic [7:0]  ALU_OUT;
  logic        ALU_OVF_OUT;

  int checks = 0;
  int errors = 0;

  logic [7:0] alu_log [4];
  int         alu_n;

  alu_wide_seq #(.NBYTES(2)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_KIND    (REQ_KIND),
    .REQ_A       (REQ_A),
    .REQ_B       (REQ_B),
    .REQ_CIN     (REQ_CIN),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_RESULT  (RSP_RESULT),
    .RSP_COUT    (RSP_COUT),
    .ABORT       (ABORT),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .ALU_OP      (ALU_OP),
    .ALU_FUNC    (ALU_FUNC),
    .ALU_OVF_IN  (ALU_OVF_IN),
    .ALU_FLAG_IN (ALU_FLAG_IN),
    .ALU_OUT     (ALU_OUT),
    .ALU_OVF_OUT (ALU_OVF_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [8:0] alu_t;
  always_comb begin
    alu_t       = 9'h000;
    ALU_OUT     = 8'h00;
    ALU_OVF_OUT = 1'b0;
    case (ALU_OP)
      opADD: begin
        alu_t       = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_OVF_IN};
        ALU_OUT     = alu_t[7:0];
        ALU_OVF_OUT = alu_t[8];
      end
      opSUB: begin
        alu_t       = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'h00, ALU_OVF_IN};
        ALU_OUT     = alu_t[7:0];
        ALU_OVF_OUT = alu_t[8];
      end
      opOTYPE: begin
        if (ALU_FUNC == fnSHIFTL_O) begin
          ALU_OUT     = {ALU_A[6:0], ALU_OVF_IN};
          ALU_OVF_OUT = ALU_A[7];
        end else if (ALU_FUNC == fnSHIFTR_O) begin
          ALU_OUT     = {ALU_OVF_IN, ALU_A[7:1]};
          ALU_OVF_OUT = ALU_A[0];
        end
      end
      default: ;
    endcase
  end

  // Drive one request, wait bounded for the response, then consume it.
  // cyc = edges from request-raise to RSP_VALID, -1 on timeout.
  task automatic do_op(input wkind_t k, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       output logic [15:0] res, output logic co,
                       output int cyc);
    int n;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_KIND  = k;
    REQ_A     = a;
    REQ_B     = b;
    REQ_CIN   = cin;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n = 1;
    alu_n = 0;
    while (!RSP_VALID && n < 20) begin
      if (!REQ_READY && alu_n < 4) begin
        alu_log[alu_n] = ALU_A;
        alu_n++;
      end
      @(posedge CLK); #1;
      n++;
    end
    res = RSP_RESULT;
    co  = RSP_COUT;
    cyc = RSP_VALID ? n : -1;
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 1", REQ_READY);
    end
    checks++;
    if (RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b want 0", RSP_VALID);
    end
    checks++;
    if (RSP_RESULT !== 16'h0000 || RSP_COUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_result got %h/%b want 0000/0",
               RSP_RESULT, RSP_COUT);
    end
    checks++;
    if (ALU_OP !== opADD || ALU_A !== 8'h00 || ALU_OVF_IN !== 1'b0) begin
      errors++;
      $display("FAIL reset_alu_idle got op=%0d a=%h ovf=%b want 0/00/0",
               ALU_OP, ALU_A, ALU_OVF_IN);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] r;
    logic c;
    int cy;
    do_op(K_ADD, 16'h00FF, 16'h0001, 1'b0, r, c, cy);
    checks++;
    if (r !== 16'h0100 || c !== 1'b0) begin
      errors++;
      $display("FAIL add_result got %h/%b want 0100/0", r, c);
    end
    checks++;
    if (cy !== 3) begin
      errors++;
      $display("FAIL add_latency got %0d want 3", cy);
    end
    checks++;
    if (alu_n !== 2 || alu_log[0] !== 8'hFF || alu_log[1] !== 8'h00) begin
      errors++;
      $display("FAIL add_alu_bytes got n=%0d %h %h want 2 ff 00",
               alu_n, alu_log[0], alu_log[1]);
    end
  endtask

  task automatic test_sub();
    logic [15:0] r;
    logic c;
    int cy;
    do_op(K_SUB, 16'h0100, 16'h0001, 1'b0, r, c, cy);
    checks++;
    if (r !== 16'h00FF || c !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow_chain got %h/%b want 00ff/0", r, c);
    end
    do_op(K_SUB, 16'h0000, 16'h0001, 1'b0, r, c, cy);
    checks++;
    if (r !== 16'hFFFF || c !== 1'b1) begin
      errors++;
      $display("FAIL sub_underflow got %h/%b want ffff/1", r, c);
    end
  endtask

  task automatic test_shl();
    logic [15:0] r;
    logic c;
    int cy;
    do_op(K_SHL, 16'h8001, 16'hFFFF, 1'b1, r, c, cy);
    checks++;
    if (r !== 16'h0003 || c !== 1'b1) begin
      errors++;
      $display("FAIL shl_result got %h/%b want 0003/1", r, c);
    end
  endtask

  task automatic test_shr();
    logic [15:0] r;
    logic c;
    int cy;
    do_op(K_SHR, 16'h0180, 16'h0000, 1'b0, r, c, cy);
    checks++;
    if (r !== 16'h00C0 || c !== 1'b0) begin
      errors++;
      $display("FAIL shr_result got %h/%b want 00c0/0", r, c);
    end
    checks++;
    if (alu_log[0] !== 8'h01 || alu_log[1] !== 8'h80) begin
      errors++;
      $display("FAIL shr_byte_order got %h %h want 01 80",
               alu_log[0], alu_log[1]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_KIND  = K_ADD;
    REQ_A     = 16'h00FF;
    REQ_B     = 16'h0001;
    REQ_CIN   = 1'b0;
    @(posedge CLK); #1;
    REQ_A = 16'h1000;
    REQ_B = 16'h0234;
    n = 0;
    while (!RSP_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (RSP_VALID !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_valid got %b want 1", RSP_VALID);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (RSP_VALID !== 1'b1 || RSP_RESULT !== 16'h0100 ||
          REQ_READY !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    checks++;
    if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1/0",
               REQ_READY, RSP_VALID);
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    checks++;
    if (REQ_READY !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got rdy=%b want 0", REQ_READY);
    end
    n = 0;
    while (!RSP_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_RESULT !== 16'h1234) begin
      errors++;
      $display("FAIL bp_second_result got %b/%h want 1/1234",
               RSP_VALID, RSP_RESULT);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] r;
    logic c;
    int cy;
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got rdy=%b want 1", REQ_READY);
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_KIND  = K_ADD;
    REQ_A     = 16'h00FF;
    REQ_B     = 16'h0001;
    REQ_CIN   = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    checks++;
    if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_to_idle got rdy=%b vld=%b want 1/0",
               REQ_READY, RSP_VALID);
    end
    @(posedge CLK); #1;
    checks++;
    if (RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rsp got vld=%b want 0", RSP_VALID);
    end
    do_op(K_ADD, 16'h1234, 16'h1111, 1'b0, r, c, cy);
    checks++;
    if (r !== 16'h2345 || c !== 1'b0 || cy !== 3) begin
      errors++;
      $display("FAIL abort_then_add got %h/%b/%0d want 2345/0/3",
               r, c, cy);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] r;
    logic c;
    int cy;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1;
    REQ_KIND  = K_ADD;
    REQ_A     = 16'hFFFF;
    REQ_B     = 16'h0001;
    REQ_CIN   = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got rdy=%b vld=%b want 1/0",
               REQ_READY, RSP_VALID);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    do_op(K_ADD, 16'h0FF0, 16'h0011, 1'b0, r, c, cy);
    checks++;
    if (r !== 16'h1001 || c !== 1'b0) begin
      errors++;
      $display("FAIL arst_then_add got %h/%b want 1001/0", r, c);
    end
  endtask

  initial begin
    REQ_VALID = 1'b0;
    REQ_KIND  = K_ADD;
    REQ_A     = 16'h0000;
    REQ_B     = 16'h0000;
    REQ_CIN   = 1'b0;
    RSP_READY = 1'b0;
    ABORT     = 1'b0;
    alu_n     = 0;
    for (int i = 0; i < 4; i++) alu_log[i] = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_shl();
    test_shr();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
